// File: rtl/frame_stack_ctrl_pkg.sv
// Shared widths, FSM encodings and address helper for the call-frame save/restore sequencer.
package frame_stack_ctrl_pkg;

  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 16;
  localparam int FRAME_W     = WORD_W * FRAME_WORDS;
  localparam int ADDR_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_SDONE   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_LWAIT   = 3'd4,
    ST_RESTORE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LOAD  = 2'd1,
    SH_SHIFT = 2'd2
  } shift_op_t;

  // Word address of word `word` in frame `frame`; wraps modulo 2^16 by design.
  function automatic logic [ADDR_W-1:0] frame_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] frame,
                                                   input logic [3:0]        word);
    return base + (frame << 4) + {12'b0, word};
  endfunction

endpackage

// File: rtl/frame_stack_ctrl_if.sv
// Data-memory port of the frame stack: one word per cycle, reads return one cycle later.
interface frame_stack_ctrl_if;
  import frame_stack_ctrl_pkg::*;

  logic [ADDR_W-1:0] memAddr;
  logic [WORD_W-1:0] memWdata;
  logic              memWe;
  logic              memRe;
  logic [WORD_W-1:0] memRdata;

  modport master (
    output memAddr, memWdata, memWe, memRe,
    input  memRdata
  );

  modport slave (
    input  memAddr, memWdata, memWe, memRe,
    output memRdata
  );

endinterface

// File: rtl/frame_stack_ctrl_shifter.sv
// 256-bit frame shadow register: parallel load, or shift right one word inserting at the top.
module frame_shifter
  import frame_stack_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  shift_op_t          op_i,
  input  logic [FRAME_W-1:0] load_i,
  input  logic [WORD_W-1:0]  ins_i,
  output logic [FRAME_W-1:0] q_o,
  output logic [FRAME_W-1:0] nxt_o
);

  logic [FRAME_W-1:0] shadow_q;
  logic [FRAME_W-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    case (op_i)
      SH_LOAD:  shadow_d = load_i;
      SH_SHIFT: shadow_d = {ins_i, shadow_q[FRAME_W-1:WORD_W]};
      default:  shadow_d = shadow_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign q_o   = shadow_q;
  assign nxt_o = shadow_d;

endmodule

// File: rtl/frame_stack_ctrl.sv
// Call-frame sequencer: spills regs 0-15 to a memory frame stack on CALL, reloads them on RETURN.
// state    | meaning
// IDLE     | waiting for callReq/retReq
// SAVE     | writing 16 shadow words to the top free frame
// SDONE    | save finished, push depth
// LOAD     | issuing 16 reads of the top frame
// LWAIT    | capturing the last read word
// RESTORE  | present rebuilt frame to regfile, pop depth
module frame_stack_ctrl
  import frame_stack_ctrl_pkg::*;
#(
  parameter int               DEPTH      = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE = 16'hF000,
  localparam int              DEPTH_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                callReq_i,
  input  logic                retReq_i,
  input  logic [FRAME_W-1:0]  fcOut_i,
  output logic [FRAME_W-1:0]  fcIn_o,
  output logic                restore_o,
  frame_stack_ctrl_if.master  mem,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic [DEPTH_W-1:0]  depth_o
);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               re_q;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [FRAME_W-1:0] fcIn_q, fcIn_d;

  shift_op_t          sh_op;
  logic [FRAME_W-1:0] sh_q;
  logic [FRAME_W-1:0] sh_nxt;

  logic               we_c, re_c, done_c, restore_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [WORD_W-1:0]  wdata_c;
  logic               full, empty;

  assign full  = (depth_q == DEPTH_W'(DEPTH));
  assign empty = (depth_q == '0);

  frame_shifter u_shifter (
    .clk    (clk),
    .reset  (reset),
    .op_i   (sh_op),
    .load_i (fcOut_i),
    .ins_i  (mem.memRdata),
    .q_o    (sh_q),
    .nxt_o  (sh_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    depth_d   = depth_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    fcIn_d    = fcIn_q;
    // Read data arrives the cycle after each strobe, so capture follows re_q.
    sh_op     = re_q ? SH_SHIFT : SH_HOLD;
    we_c      = 1'b0;
    re_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    done_c    = 1'b0;
    restore_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (callReq_i) begin
          if (!full) begin
            state_d = ST_SAVE;
            cnt_d   = '0;
            sh_op   = SH_LOAD;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (retReq_i) begin
          if (!empty) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      ST_SAVE: begin
        we_c    = 1'b1;
        addr_c  = frame_addr(STACK_BASE, ADDR_W'(depth_q), cnt_q);
        wdata_c = sh_q[WORD_W-1:0];
        sh_op   = SH_SHIFT;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_SDONE;
      end
      ST_SDONE: begin
        done_c  = 1'b1;
        depth_d = depth_q + DEPTH_W'(1);
        state_d = ST_IDLE;
      end
      ST_LOAD: begin
        re_c   = 1'b1;
        addr_c = frame_addr(STACK_BASE, ADDR_W'(depth_q) - 16'd1, cnt_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_LWAIT;
      end
      ST_LWAIT: begin
        fcIn_d  = sh_nxt;
        state_d = ST_RESTORE;
      end
      ST_RESTORE: begin
        restore_c = 1'b1;
        done_c    = 1'b1;
        depth_d   = depth_q - DEPTH_W'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      depth_q <= '0;
      re_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      fcIn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      re_q    <= re_c;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      fcIn_q  <= fcIn_d;
    end
  end

  assign mem.memAddr  = addr_c;
  assign mem.memWdata = wdata_c;
  assign mem.memWe    = we_c;
  assign mem.memRe    = re_c;

  assign fcIn_o      = fcIn_q;
  assign restore_o   = restore_c;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_c;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign depth_o     = depth_q;

endmodule

// File: tb/tb_frame_stack_ctrl.sv
// Directed bench for frame_stack_ctrl with a two-frame stack and a word-addressed memory model.
module tb_frame_stack_ctrl;
  import frame_stack_ctrl_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               callReq = 1'b0;
  logic               retReq = 1'b0;
  logic [FRAME_W-1:0] fcOut = '0;
  logic [FRAME_W-1:0] fcIn;
  logic               restore, busy, done, overflow, underflow;
  logic [DW-1:0]      depth;

  frame_stack_ctrl_if mem_if ();

  frame_stack_ctrl #(.DEPTH(DEPTH), .STACK_BASE(16'hF000)) dut (
    .clk         (clk),
    .reset       (reset),
    .callReq_i   (callReq),
    .retReq_i    (retReq),
    .fcOut_i     (fcOut),
    .fcIn_o      (fcIn),
    .restore_o   (restore),
    .mem         (mem_if),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow),
    .underflow_o (underflow),
    .depth_o     (depth)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_model [0:65535];
  int done_cnt = 0;
  int re_cnt   = 0;
  int both_cnt = 0;
  int hit_f020 = 0;

  always @(posedge clk) begin
    if (reset) mem_if.memRdata <= '0;
    else if (mem_if.memRe) mem_if.memRdata <= mem_model[mem_if.memAddr];
    if (mem_if.memWe) mem_model[mem_if.memAddr] <= mem_if.memWdata;
    if (mem_if.memWe && mem_if.memAddr == 16'hF020) hit_f020 <= hit_f020 + 1;
    if (mem_if.memWe && mem_if.memRe) both_cnt <= both_cnt + 1;
    if (mem_if.memRe) re_cnt <= re_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [3:0] hi_a, input logic [3:0] hi_b);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[16*k +: 16] = {hi_a, 4'(k), hi_b, 4'(k)};
    return f;
  endfunction

  task automatic do_call(input logic [FRAME_W-1:0] frame, input logic [15:0] base,
                         input logic [DW-1:0] depth_after, input bit ret_too);
    callReq = 1'b1;
    retReq  = ret_too;
    fcOut   = frame;
    @(negedge clk);
    callReq = 1'b0;
    retReq  = 1'b0;
    fcOut   = ~frame;
    for (int k = 0; k < 16; k++) begin
      chk("save_we",   mem_if.memWe, 1);
      chk("save_re",   mem_if.memRe, 0);
      chk("save_addr", mem_if.memAddr, 16'(base + 16'(k)));
      chk("save_data", mem_if.memWdata, frame[16*k +: 16]);
      chk("save_busy", busy, 1);
      retReq = ret_too && (k == 4);
      @(negedge clk);
    end
    retReq = 1'b0;
    chk("sdone_done", done, 1);
    chk("sdone_we",   mem_if.memWe, 0);
    chk("sdone_addr", mem_if.memAddr, 0);
    @(negedge clk);
    chk("call_depth", depth, depth_after);
    chk("call_busy",  busy, 0);
    chk("call_done",  done, 0);
  endtask

  task automatic do_ret(input logic [FRAME_W-1:0] frame, input logic [15:0] base,
                        input logic [DW-1:0] depth_after);
    retReq = 1'b1;
    @(negedge clk);
    retReq = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("load_re",      mem_if.memRe, 1);
      chk("load_we",      mem_if.memWe, 0);
      chk("load_addr",    mem_if.memAddr, 16'(base + 16'(k)));
      chk("load_restore", restore, 0);
      @(negedge clk);
    end
    chk("lwait_re",      mem_if.memRe, 0);
    chk("lwait_restore", restore, 0);
    chk("lwait_done",    done, 0);
    @(negedge clk);
    chk("rst_restore", restore, 1);
    chk("rst_done",    done, 1);
    chk("rst_fcin",    fcIn, frame);
    @(negedge clk);
    chk("ret_restore", restore, 0);
    chk("ret_done",    done, 0);
    chk("ret_depth",   depth, depth_after);
    chk("ret_hold",    fcIn, frame);
    chk("ret_busy",    busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] f1, f2, f3;
    int d0, r0;
    f1 = mk_frame(4'h0, 4'h0);
    f2 = mk_frame(4'hA, 4'h5);
    f3 = mk_frame(4'hC, 4'h3);

    @(negedge clk);
    @(negedge clk);
    chk("reset_busy",  busy, 0);
    chk("reset_depth", depth, 0);
    chk("reset_fcin",  fcIn, 0);
    chk("reset_we",    mem_if.memWe, 0);
    chk("reset_re",    mem_if.memRe, 0);
    chk("reset_addr",  mem_if.memAddr, 0);
    chk("reset_done",  done, 0);
    chk("reset_rest",  restore, 0);
    reset = 1'b0;
    @(negedge clk);

    // first save: words 0000,0101..0F0F at F000..F00F
    chk("f1_word1_const",  f1[31:16], 16'h0101);
    do_call(f1, 16'hF000, 1, 1'b0);
    chk("mem_f000", mem_model[16'hF000], 16'h0000);
    chk("mem_f005", mem_model[16'hF005], 16'h0505);
    chk("mem_f00f", mem_model[16'hF00F], 16'h0F0F);
    do_ret(f1, 16'hF000, 0);

    r0 = re_cnt;
    retReq = 1'b1;
    @(negedge clk);
    retReq = 1'b0;
    chk("unf_pulse", underflow, 1);
    chk("unf_re",    mem_if.memRe, 0);
    chk("unf_busy",  busy, 0);
    @(negedge clk);
    chk("unf_clear", underflow, 0);
    chk("unf_depth", depth, 0);
    chk("unf_busy2", busy, 0);
    chk("unf_noread", 32'(re_cnt), 32'(r0));

    do_call(f1, 16'hF000, 1, 1'b0);
    d0 = done_cnt;
    r0 = re_cnt;
    do_call(f2, 16'hF010, 2, 1'b1);
    chk("both_one_done", 32'(done_cnt), 32'(d0 + 1));
    chk("both_no_read",  32'(re_cnt), 32'(r0));
    chk("mem_f010", mem_model[16'hF010], 16'hA050);
    chk("mem_f01b", mem_model[16'hF01B], 16'hAB5B);
    chk("mem_f003", mem_model[16'hF003], 16'h0303);

    callReq = 1'b1;
    fcOut   = f3;
    @(negedge clk);
    callReq = 1'b0;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_we",    mem_if.memWe, 0);
    chk("ovf_busy",  busy, 0);
    @(negedge clk);
    chk("ovf_clear", overflow, 0);
    repeat (20) @(negedge clk);
    chk("ovf_no_f020", 32'(hit_f020), 0);
    chk("ovf_depth",   depth, 2);

    do_ret(f2, 16'hF010, 1);

    callReq = 1'b1;
    fcOut   = f3;
    @(negedge clk);
    callReq = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_addr7", mem_if.memAddr, 16'hF017);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we",    mem_if.memWe, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_depth", depth, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_f018_kept", mem_model[16'hF018], 16'hA858);
    do_call(f3, 16'hF000, 1, 1'b0);
    chk("never_both", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
